// File: rtl/pic_seq_pkg.sv
// rtl/pic_seq_pkg.sv - shared types and constants for the 8259A init/command sequencer
//
// Contents:
//   seq_state_e            sequencer state encoding
//   ICW1_IC4, ICW1_SNGL    bit positions inside ICW1
//   CMD_D3, CMD_D4         data-bit positions used to classify a0=0 writes
//   OCW3_RESET             OCW3 value after reset or ICW1 (read IRR, no SMM)
//   TIMEOUT_CYCLES_DEFAULT default ICW-to-ICW watchdog budget
//   is_wait_state()        true for the three WAIT_* states
package pic_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } seq_state_e;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_D3    = 3;
    localparam int CMD_D4    = 4;

    localparam logic [7:0] OCW3_RESET = 8'h0A;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_WAIT_ICW2) || (s == ST_WAIT_ICW3) || (s == ST_WAIT_ICW4);
    endfunction

endpackage

// File: rtl/pic_seq_watchdog.sv
// rtl/pic_seq_watchdog.sv - loadable up/down counter with terminal-count expire flag
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   clr       force count to zero (highest priority)
//   load      load load_val into the count
//   load_val  value loaded when load=1
//   en        count enable
//   up        1 = count toward LIMIT-1, 0 = count toward zero
//   expire    combinational: enabled and sitting at the terminal count
//   count     current count
module pic_seq_watchdog #(
    parameter int LIMIT = 1024,
    parameter int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic             expire,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    // Terminal count depends on direction: LIMIT-1 going up, zero going down.
    assign at_term = up ? (cnt_q == TERM) : (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && !at_term) begin
            // Saturate at the terminal count; the owner decides what expiry means.
            cnt_d = up ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && at_term;
    assign count  = cnt_q;

endmodule

// File: rtl/pic_init_sequencer.sv
// rtl/pic_init_sequencer.sv - 8259A write-side ICW/OCW sequencer and command-word registers
//
// Optional feature macro: PIC_INIT_WATCHDOG_EN (ICW-to-ICW timeout watchdog).
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst_n         synchronous active-low reset
//   wr_stb        one-cycle qualified write strobe
//   a0            register address bit
//   din           write data
//   icw1..icw4    initialization command words
//   ocw1..ocw3    operation command words
//   init_done     high while the sequencer is in READY
//   ocw2_stb      one-cycle pulse after an accepted OCW2 write
//   ocw3_stb      one-cycle pulse after an accepted OCW3 write
//   seq_err       sticky flag for writes illegal in the current state
//   init_timeout  one-cycle pulse on watchdog abort (0 without the macro)
module pic_init_sequencer
    import pic_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_stb,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] icw1,
    output logic [7:0] icw2,
    output logic [7:0] icw3,
    output logic [7:0] icw4,
    output logic [7:0] ocw1,
    output logic [7:0] ocw2,
    output logic [7:0] ocw3,
    output logic       init_done,
    output logic       ocw2_stb,
    output logic       ocw3_stb,
    output logic       seq_err,
    output logic       init_timeout
);

    seq_state_e state_q, state_d;
    logic [7:0] icw1_q, icw1_d;
    logic [7:0] icw2_q, icw2_d;
    logic [7:0] icw3_q, icw3_d;
    logic [7:0] icw4_q, icw4_d;
    logic [7:0] ocw1_q, ocw1_d;
    logic [7:0] ocw2_q, ocw2_d;
    logic [7:0] ocw3_q, ocw3_d;
    logic       init_done_q, init_done_d;
    logic       ocw2_stb_q, ocw2_stb_d;
    logic       ocw3_stb_q, ocw3_stb_d;
    logic       seq_err_q, seq_err_d;
    logic       init_timeout_q, init_timeout_d;

    // Write classification. ICW1 is recognised by D4 regardless of state.
    logic wr_icw1;
    logic wr_data;
    logic wr_ocw2;
    logic wr_ocw3;
    logic in_wait;
    logic accepted_icw;
    logic wd_expire;

    assign wr_icw1 = wr_stb && !a0 &&  din[CMD_D4];
    assign wr_data = wr_stb &&  a0;
    assign wr_ocw2 = wr_stb && !a0 && !din[CMD_D4] && !din[CMD_D3];
    assign wr_ocw3 = wr_stb && !a0 && !din[CMD_D4] &&  din[CMD_D3];

    assign in_wait      = is_wait_state(state_q);
    // Any ICW that advances (or restarts) initialization resets the watchdog.
    assign accepted_icw = wr_icw1 || (wr_data && in_wait);

`ifdef PIC_INIT_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_count;

    // Counter is held at zero outside WAIT_* so each wait starts a fresh budget.
    pic_seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accepted_icw || !in_wait),
        .load     (1'b0),
        .load_val ('0),
        .en       (in_wait),
        .up       (1'b1),
        .expire   (wd_expire),
        .count    (wd_count)
    );

    logic wd_count_unused;
    assign wd_count_unused = ^wd_count;
`else
    // No watchdog: the parameter is still referenced so both builds share one
    // parameter list, but expiry can never occur.
    assign wd_expire = 1'b0 & (TIMEOUT_CYCLES >= 2);
`endif

    always_comb begin
        state_d        = state_q;
        icw1_d         = icw1_q;
        icw2_d         = icw2_q;
        icw3_d         = icw3_q;
        icw4_d         = icw4_q;
        ocw1_d         = ocw1_q;
        ocw2_d         = ocw2_q;
        ocw3_d         = ocw3_q;
        seq_err_d      = seq_err_q;
        ocw2_stb_d     = 1'b0;
        ocw3_stb_d     = 1'b0;
        init_timeout_d = 1'b0;

        if (wr_icw1) begin
            // ICW1 restarts initialization from any state. OCW2 is left alone:
            // it carries no persistent mode that ICW1 is defined to reset.
            icw1_d    = din;
            icw2_d    = 8'h00;
            icw3_d    = 8'h00;
            icw4_d    = 8'h00;
            ocw1_d    = 8'h00;
            ocw3_d    = OCW3_RESET;
            seq_err_d = 1'b0;
            state_d   = ST_WAIT_ICW2;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Nothing but ICW1 is meaningful before initialization.
                    if (wr_stb) begin
                        seq_err_d = 1'b1;
                    end
                end
                ST_WAIT_ICW2: begin
                    if (wr_data) begin
                        icw2_d = din;
                        if (!icw1_q[ICW1_SNGL]) begin
                            state_d = ST_WAIT_ICW3;
                        end else if (icw1_q[ICW1_IC4]) begin
                            state_d = ST_WAIT_ICW4;
                        end else begin
                            state_d = ST_READY;
                        end
                    end else if (wr_stb) begin
                        seq_err_d = 1'b1;
                    end
                end
                ST_WAIT_ICW3: begin
                    if (wr_data) begin
                        icw3_d  = din;
                        state_d = icw1_q[ICW1_IC4] ? ST_WAIT_ICW4 : ST_READY;
                    end else if (wr_stb) begin
                        seq_err_d = 1'b1;
                    end
                end
                ST_WAIT_ICW4: begin
                    if (wr_data) begin
                        icw4_d  = din;
                        state_d = ST_READY;
                    end else if (wr_stb) begin
                        seq_err_d = 1'b1;
                    end
                end
                ST_READY: begin
                    if (wr_data) begin
                        ocw1_d = din;
                    end else if (wr_ocw2) begin
                        ocw2_d     = din;
                        ocw2_stb_d = 1'b1;
                    end else if (wr_ocw3) begin
                        ocw3_d     = din;
                        ocw3_stb_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Abort only when no ICW lands on the expiry cycle; icw* are kept
            // so software can inspect how far initialization got.
            if (wd_expire && !accepted_icw) begin
                state_d        = ST_IDLE;
                init_timeout_d = 1'b1;
            end
        end

        init_done_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            icw1_q         <= 8'h00;
            icw2_q         <= 8'h00;
            icw3_q         <= 8'h00;
            icw4_q         <= 8'h00;
            ocw1_q         <= 8'h00;
            ocw2_q         <= 8'h00;
            ocw3_q         <= OCW3_RESET;
            init_done_q    <= 1'b0;
            ocw2_stb_q     <= 1'b0;
            ocw3_stb_q     <= 1'b0;
            seq_err_q      <= 1'b0;
            init_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            icw1_q         <= icw1_d;
            icw2_q         <= icw2_d;
            icw3_q         <= icw3_d;
            icw4_q         <= icw4_d;
            ocw1_q         <= ocw1_d;
            ocw2_q         <= ocw2_d;
            ocw3_q         <= ocw3_d;
            init_done_q    <= init_done_d;
            ocw2_stb_q     <= ocw2_stb_d;
            ocw3_stb_q     <= ocw3_stb_d;
            seq_err_q      <= seq_err_d;
            init_timeout_q <= init_timeout_d;
        end
    end

    assign icw1         = icw1_q;
    assign icw2         = icw2_q;
    assign icw3         = icw3_q;
    assign icw4         = icw4_q;
    assign ocw1         = ocw1_q;
    assign ocw2         = ocw2_q;
    assign ocw3         = ocw3_q;
    assign init_done    = init_done_q;
    assign ocw2_stb     = ocw2_stb_q;
    assign ocw3_stb     = ocw3_stb_q;
    assign seq_err      = seq_err_q;
    assign init_timeout = init_timeout_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// tb/tb_pic_init_sequencer.sv - directed self-checking bench for pic_init_sequencer
module tb_pic_init_sequencer;

    logic       clk;
    logic       rst_n;
    logic       wr_stb;
    logic       a0;
    logic [7:0] din;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic [7:0] ocw1, ocw2, ocw3;
    logic       init_done, ocw2_stb, ocw3_stb, seq_err, init_timeout;

    int n_checks;
    int n_errors;

    pic_init_sequencer #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_stb       (wr_stb),
        .a0           (a0),
        .din          (din),
        .icw1         (icw1),
        .icw2         (icw2),
        .icw3         (icw3),
        .icw4         (icw4),
        .ocw1         (ocw1),
        .ocw2         (ocw2),
        .ocw3         (ocw3),
        .init_done    (init_done),
        .ocw2_stb     (ocw2_stb),
        .ocw3_stb     (ocw3_stb),
        .seq_err      (seq_err),
        .init_timeout (init_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one write for the next rising edge and
    // returns at the following negedge, i.e. in cycle N+1.
    task automatic wr(input logic addr, input logic [7:0] data);
        wr_stb = 1'b1;
        a0     = addr;
        din    = data;
        @(negedge clk);
        wr_stb = 1'b0;
        a0     = 1'b0;
        din    = 8'h00;
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_icw1"}, icw1, 8'h00);
        chk({pfx, "_icw2"}, icw2, 8'h00);
        chk({pfx, "_icw3"}, icw3, 8'h00);
        chk({pfx, "_icw4"}, icw4, 8'h00);
        chk({pfx, "_ocw1"}, ocw1, 8'h00);
        chk({pfx, "_ocw2"}, ocw2, 8'h00);
        chk({pfx, "_ocw3"}, ocw3, 8'h0A);
        chk({pfx, "_init_done"}, {7'd0, init_done}, 8'h00);
        chk({pfx, "_ocw2_stb"}, {7'd0, ocw2_stb}, 8'h00);
        chk({pfx, "_ocw3_stb"}, {7'd0, ocw3_stb}, 8'h00);
        chk({pfx, "_seq_err"}, {7'd0, seq_err}, 8'h00);
        chk({pfx, "_timeout"}, {7'd0, init_timeout}, 8'h00);
    endtask

    initial begin
        logic seen;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        wr_stb   = 1'b0;
        a0       = 1'b0;
        din      = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Illegal writes before any ICW1
        wr(1'b1, 8'h55);
        chk("idle_a0_seq_err", {7'd0, seq_err}, 8'h01);
        chk("idle_a0_ocw1", ocw1, 8'h00);
        chk("idle_a0_done", {7'd0, init_done}, 8'h00);
        wr(1'b0, 8'h20);
        chk("idle_ocw2_ign", ocw2, 8'h00);
        chk("idle_ocw2_nostb", {7'd0, ocw2_stb}, 8'h00);

        // Single, no ICW4
        wr(1'b0, 8'h12);
        chk("t1_icw1", icw1, 8'h12);
        chk("t1_err_clr", {7'd0, seq_err}, 8'h00);
        chk("t1_done_lo", {7'd0, init_done}, 8'h00);
        wr(1'b1, 8'h40);
        chk("t1_icw2", icw2, 8'h40);
        chk("t1_done", {7'd0, init_done}, 8'h01);
        chk("t1_icw3", icw3, 8'h00);
        chk("t1_icw4", icw4, 8'h00);

        // READY operations
        wr(1'b1, 8'hF0);
        chk("rdy_ocw1", ocw1, 8'hF0);
        chk("rdy_ocw1_no2", {7'd0, ocw2_stb}, 8'h00);
        chk("rdy_ocw1_no3", {7'd0, ocw3_stb}, 8'h00);
        wr(1'b0, 8'h20);
        chk("rdy_ocw2", ocw2, 8'h20);
        chk("rdy_ocw2_stb", {7'd0, ocw2_stb}, 8'h01);
        @(negedge clk);
        chk("rdy_ocw2_stb_off", {7'd0, ocw2_stb}, 8'h00);
        wr(1'b0, 8'h0B);
        chk("rdy_ocw3", ocw3, 8'h0B);
        chk("rdy_ocw3_stb", {7'd0, ocw3_stb}, 8'h01);
        chk("rdy_ocw3_no2", {7'd0, ocw2_stb}, 8'h00);

        // Back-to-back OCW2 then OCW3
        wr(1'b0, 8'h60);
        chk("b2b_ocw2", ocw2, 8'h60);
        chk("b2b_ocw2_stb", {7'd0, ocw2_stb}, 8'h01);
        wr(1'b0, 8'h0C);
        chk("b2b_ocw3", ocw3, 8'h0C);
        chk("b2b_ocw3_stb", {7'd0, ocw3_stb}, 8'h01);
        chk("b2b_ocw2_off", {7'd0, ocw2_stb}, 8'h00);
        @(negedge clk);
        chk("b2b_ocw3_off", {7'd0, ocw3_stb}, 8'h00);

        // Cascade with ICW4, plus an illegal OCW mid-sequence
        wr(1'b0, 8'h11);
        chk("t2_icw1", icw1, 8'h11);
        chk("t2_done_lo", {7'd0, init_done}, 8'h00);
        chk("t2_ocw1_clr", ocw1, 8'h00);
        chk("t2_ocw3_rst", ocw3, 8'h0A);
        chk("t2_ocw2_kept", ocw2, 8'h60);
        wr(1'b1, 8'h08);
        chk("t2_icw2", icw2, 8'h08);
        chk("t2_done_w3", {7'd0, init_done}, 8'h00);
        wr(1'b0, 8'h20);
        chk("t2_wait_err", {7'd0, seq_err}, 8'h01);
        chk("t2_wait_ocw2", ocw2, 8'h60);
        chk("t2_wait_nostb", {7'd0, ocw2_stb}, 8'h00);
        wr(1'b1, 8'h04);
        chk("t2_icw3", icw3, 8'h04);
        chk("t2_done_w4", {7'd0, init_done}, 8'h00);
        wr(1'b1, 8'h01);
        chk("t2_icw4", icw4, 8'h01);
        chk("t2_done", {7'd0, init_done}, 8'h01);

        // Restart from WAIT_ICW3
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h0B);
        chk("rs_err", {7'd0, seq_err}, 8'h01);
        chk("rs_ocw3_ign", ocw3, 8'h0A);
        wr(1'b0, 8'h13);
        chk("rs_icw1", icw1, 8'h13);
        chk("rs_icw2", icw2, 8'h00);
        chk("rs_ocw1", ocw1, 8'h00);
        chk("rs_ocw3", ocw3, 8'h0A);
        chk("rs_err_clr", {7'd0, seq_err}, 8'h00);
        chk("rs_done", {7'd0, init_done}, 8'h00);
        wr(1'b1, 8'h20);
        chk("rs_icw2_new", icw2, 8'h20);
        chk("rs_done_w4", {7'd0, init_done}, 8'h00);
        wr(1'b1, 8'h03);
        chk("rs_icw4", icw4, 8'h03);
        chk("rs_icw3_skip", icw3, 8'h00);
        chk("rs_done_rdy", {7'd0, init_done}, 8'h01);

`ifdef PIC_INIT_WATCHDOG_EN
        // Timeout: ICW1 then silence for 16 cycles
        wr(1'b0, 8'h11);
        repeat (15) @(negedge clk);
        chk("wd_before", {7'd0, init_timeout}, 8'h00);
        @(negedge clk);
        chk("wd_pulse", {7'd0, init_timeout}, 8'h01);
        chk("wd_done", {7'd0, init_done}, 8'h00);
        chk("wd_icw1_kept", icw1, 8'h11);
        @(negedge clk);
        chk("wd_pulse_end", {7'd0, init_timeout}, 8'h00);
        wr(1'b1, 8'h55);
        chk("wd_idle_err", {7'd0, seq_err}, 8'h01);
        chk("wd_idle_icw2", icw2, 8'h00);
        // A write on the expiry cycle beats the timeout
        wr(1'b0, 8'h11);
        repeat (15) @(negedge clk);
        wr(1'b1, 8'h08);
        chk("wd_win_icw2", icw2, 8'h08);
        chk("wd_win_nopulse", {7'd0, init_timeout}, 8'h00);
        @(negedge clk);
        chk("wd_win_nopulse2", {7'd0, init_timeout}, 8'h00);
`else
        // No watchdog: WAIT_* waits indefinitely
        wr(1'b0, 8'h11);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | init_timeout;
        end
        chk("nowd_no_timeout", {7'd0, seen}, 8'h00);
        wr(1'b1, 8'h08);
        chk("nowd_icw2", icw2, 8'h08);
        chk("nowd_done", {7'd0, init_done}, 8'h00);
`endif

        // Reset together with a write strobe: reset wins
        rst_n  = 1'b0;
        wr_stb = 1'b1;
        a0     = 1'b0;
        din    = 8'h13;
        @(negedge clk);
        wr_stb = 1'b0;
        din    = 8'h00;
        chk_reset_values("rstwr");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_icw1", icw1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
